// File: rtl/multicycle_ctrl_if.sv
// multicycle_ctrl_if: control bundle between the multi-cycle sequencer and
// the CPU datapath. The sequencer side (master) receives opcode, the ALU zero
// flag and the memory ready strobe. It drives every mux select and write
// enable, plus the state and performance-counter observation ports.
interface multicycle_ctrl_if;
    // Datapath -> sequencer
    logic [5:0]  opcode_i;
    logic        zero_i;
    logic        mem_ready_i;

    // Sequencer -> datapath
    logic        pc_write_o;
    logic        ir_write_o;
    logic        reg_write_o;
    logic        reg_dst_o;
    logic        mem_to_reg_o;
    logic        mem_read_o;
    logic        mem_write_o;
    logic        alu_src_a_o;
    logic [1:0]  alu_src_b_o;
    logic [2:0]  alu_op_o;
    logic [1:0]  pc_source_o;
    logic [3:0]  state_o;
    logic        illegal_o;
    logic [31:0] cycle_cnt_o;
    logic [31:0] retire_cnt_o;

    modport master (
        input  opcode_i,
        input  zero_i,
        input  mem_ready_i,
        output pc_write_o,
        output ir_write_o,
        output reg_write_o,
        output reg_dst_o,
        output mem_to_reg_o,
        output mem_read_o,
        output mem_write_o,
        output alu_src_a_o,
        output alu_src_b_o,
        output alu_op_o,
        output pc_source_o,
        output state_o,
        output illegal_o,
        output cycle_cnt_o,
        output retire_cnt_o
    );

    modport slave (
        output opcode_i,
        output zero_i,
        output mem_ready_i,
        input  pc_write_o,
        input  ir_write_o,
        input  reg_write_o,
        input  reg_dst_o,
        input  mem_to_reg_o,
        input  mem_read_o,
        input  mem_write_o,
        input  alu_src_a_o,
        input  alu_src_b_o,
        input  alu_op_o,
        input  pc_source_o,
        input  state_o,
        input  illegal_o,
        input  cycle_cnt_o,
        input  retire_cnt_o
    );
endinterface

// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: Moore sequencer for the multi-cycle CPU datapath.
// It walks FETCH/DECODE/EXECUTE/MEMORY/WRITEBACK per opcode and drives every
// datapath select and write enable. It stalls in FETCH, MEM_RD and MEM_WR
// until the memory signals ready.
// Optional feature: define MULTICYCLE_CTRL_PERF_EN to build the cycle and
// retired-instruction counters. Without it both counter ports read 0 and no
// counter flops exist.
module multicycle_ctrl (
    input  logic              clk_i,
    input  logic              rst_i,
    multicycle_ctrl_if.master ctrl
);

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEM_ADDR = 4'd2,
        S_MEM_RD   = 4'd3,
        S_MEM_WB   = 4'd4,
        S_MEM_WR   = 4'd5,
        S_EXEC_R   = 4'd6,
        S_R_WB     = 4'd7,
        S_BRANCH   = 4'd8,
        S_JUMP     = 4'd9,
        S_EXEC_I   = 4'd10,
        S_I_WB     = 4'd11
    } state_t;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_SLTI  = 6'b001010;

    state_t state_q;

    logic       legal_op;
    logic       pc_write;
    logic       ir_write;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       mem_read;
    logic       mem_write;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [2:0] alu_op;
    logic [1:0] pc_source;
    logic       illegal;

    // Opcode classification used by DECODE for dispatch and illegal flagging
    always_comb begin
        legal_op = 1'b0;
        case (ctrl.opcode_i)
            OP_RTYPE, OP_LW, OP_SW, OP_BEQ,
            OP_J, OP_ADDI, OP_SLTI: legal_op = 1'b1;
            default:                legal_op = 1'b0;
        endcase
    end

    // Sequencer state register with per-opcode next-state selection
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_FETCH;
        end else begin
            case (state_q)
                S_FETCH: begin
                    if (ctrl.mem_ready_i) state_q <= S_DECODE;
                end
                S_DECODE: begin
                    case (ctrl.opcode_i)
                        OP_RTYPE:         state_q <= S_EXEC_R;
                        OP_LW, OP_SW:     state_q <= S_MEM_ADDR;
                        OP_BEQ:           state_q <= S_BRANCH;
                        OP_J:             state_q <= S_JUMP;
                        OP_ADDI, OP_SLTI: state_q <= S_EXEC_I;
                        default:          state_q <= S_FETCH;
                    endcase
                end
                // Only lw/sw reach here; the IR still holds the opcode.
                S_MEM_ADDR: state_q <= (ctrl.opcode_i == OP_SW) ? S_MEM_WR : S_MEM_RD;
                S_MEM_RD: begin
                    if (ctrl.mem_ready_i) state_q <= S_MEM_WB;
                end
                S_MEM_WB: state_q <= S_FETCH;
                S_MEM_WR: begin
                    if (ctrl.mem_ready_i) state_q <= S_FETCH;
                end
                S_EXEC_R: state_q <= S_R_WB;
                S_R_WB:   state_q <= S_FETCH;
                S_BRANCH: state_q <= S_FETCH;
                S_JUMP:   state_q <= S_FETCH;
                S_EXEC_I: state_q <= S_I_WB;
                S_I_WB:   state_q <= S_FETCH;
                default:  state_q <= S_FETCH;
            endcase
        end
    end

    // Control word decode from current state (ready/zero gate the PC/IR loads)
    always_comb begin
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        reg_write  = 1'b0;
        reg_dst    = 1'b0;
        mem_to_reg = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        alu_src_a  = 1'b0;
        alu_src_b  = 2'b00;
        alu_op     = 3'b000;
        pc_source  = 2'b00;
        illegal    = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_read  = 1'b1;
                alu_src_b = 2'b01;
                ir_write  = ctrl.mem_ready_i;
                pc_write  = ctrl.mem_ready_i;
            end
            S_DECODE: begin
                alu_src_b = 2'b11;
                illegal   = ~legal_op;
            end
            S_MEM_ADDR: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
            end
            S_MEM_WB: begin
                reg_write  = 1'b1;
                mem_to_reg = 1'b1;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
            end
            S_EXEC_R: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b010;
            end
            S_R_WB: begin
                reg_write = 1'b1;
                reg_dst   = 1'b1;
            end
            S_BRANCH: begin
                alu_src_a = 1'b1;
                alu_op    = 3'b001;
                pc_source = 2'b01;
                pc_write  = ctrl.zero_i;
            end
            S_JUMP: begin
                pc_source = 2'b10;
                pc_write  = 1'b1;
            end
            S_EXEC_I: begin
                alu_src_a = 1'b1;
                alu_src_b = 2'b10;
                alu_op    = (ctrl.opcode_i == OP_SLTI) ? 3'b011 : 3'b000;
            end
            S_I_WB: begin
                reg_write = 1'b1;
            end
            default: begin
                pc_write = 1'b0;
            end
        endcase
    end

    // Enables and memory strobes are suppressed while reset is asserted so an
    // abandoned instruction never issues a write or a new memory request.
    assign ctrl.pc_write_o   = pc_write  & ~rst_i;
    assign ctrl.ir_write_o   = ir_write  & ~rst_i;
    assign ctrl.reg_write_o  = reg_write & ~rst_i;
    assign ctrl.mem_read_o   = mem_read  & ~rst_i;
    assign ctrl.mem_write_o  = mem_write & ~rst_i;
    assign ctrl.reg_dst_o    = reg_dst;
    assign ctrl.mem_to_reg_o = mem_to_reg;
    assign ctrl.alu_src_a_o  = alu_src_a;
    assign ctrl.alu_src_b_o  = alu_src_b;
    assign ctrl.alu_op_o     = alu_op;
    assign ctrl.pc_source_o  = pc_source;
    assign ctrl.illegal_o    = illegal;
    assign ctrl.state_o      = state_q;

`ifdef MULTICYCLE_CTRL_PERF_EN
    logic [31:0] cycle_cnt_q;
    logic [31:0] retire_cnt_q;
    logic        retire_evt;

    // An instruction retires when a completing state hands back to FETCH;
    // an illegal DECODE also returns to FETCH but does not count.
    always_comb begin
        retire_evt = 1'b0;
        case (state_q)
            S_MEM_WB, S_R_WB, S_I_WB,
            S_BRANCH, S_JUMP: retire_evt = 1'b1;
            S_MEM_WR:         retire_evt = ctrl.mem_ready_i;
            default:          retire_evt = 1'b0;
        endcase
    end

    // Free-running cycle and retire counters, wrapping naturally at 2^32
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cycle_cnt_q  <= '0;
            retire_cnt_q <= '0;
        end else begin
            cycle_cnt_q <= cycle_cnt_q + 32'd1;
            if (retire_evt) retire_cnt_q <= retire_cnt_q + 32'd1;
        end
    end

    assign ctrl.cycle_cnt_o  = cycle_cnt_q;
    assign ctrl.retire_cnt_o = retire_cnt_q;
`else
    assign ctrl.cycle_cnt_o  = '0;
    assign ctrl.retire_cnt_o = '0;
`endif

endmodule
